// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light FSM and its phase timer:
// phase codes, the per-phase duration limit and the countdown width.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PHASE_GREEN   = 2'b00,
    PHASE_YELLOW  = 2'b01,
    PHASE_RED     = 2'b10,
    PHASE_ILLEGAL = 2'b11
  } phase_e;

  localparam int MAX_SEC = 99;
  localparam int REM_W   = 7;

  // Packs a 0..99 value into {tens, ones} BCD digits.
  function automatic logic [7:0] to_bcd(input int unsigned value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(value / 10);
    ones = 4'(value % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: tick is high for one cycle every TICK_DIV clocks,
// and clear restarts the period so the next tick is a full TICK_DIV away.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  generate
    if (TICK_DIV < 2) begin : g_bad_div
      $error("tick_gen: TICK_DIV must be at least 2");
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase countdown for the traffic light: loads the duration of the phase
// being entered, counts it down once per second in binary and BCD, and flags expiry.
module traffic_phase_timer
  import traffic_light_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int GREEN_SEC  = 30,
  parameter int YELLOW_SEC = 3,
  parameter int RED_SEC    = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       current_state,
  input  logic             timer_load,
  output logic             timer_zero,
  output logic [REM_W-1:0] remaining,
  output logic [3:0]       remaining_tens,
  output logic [3:0]       remaining_ones
);

  localparam logic [7:0] GREEN_BCD  = to_bcd(GREEN_SEC);
  localparam logic [7:0] YELLOW_BCD = to_bcd(YELLOW_SEC);
  localparam logic [7:0] RED_BCD    = to_bcd(RED_SEC);

  generate
    if (GREEN_SEC < 1 || GREEN_SEC > MAX_SEC) begin : g_bad_green
      $error("traffic_phase_timer: GREEN_SEC out of range 1..99");
    end
    if (YELLOW_SEC < 1 || YELLOW_SEC > MAX_SEC) begin : g_bad_yellow
      $error("traffic_phase_timer: YELLOW_SEC out of range 1..99");
    end
    if (RED_SEC < 1 || RED_SEC > MAX_SEC) begin : g_bad_red
      $error("traffic_phase_timer: RED_SEC out of range 1..99");
    end
  endgenerate

  logic             tick;
  logic             armed;
  logic [REM_W-1:0] load_bin;
  logic [3:0]       load_tens;
  logic [3:0]       load_ones;

  // A load restarts the prescaler so the first second of a phase is complete.
  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_load),
    .tick  (tick)
  );

  // The illegal code falls back to green so a glitched FSM still gets a sane phase.
  always_comb begin
    load_bin  = REM_W'(GREEN_SEC);
    load_tens = GREEN_BCD[7:4];
    load_ones = GREEN_BCD[3:0];
    case (phase_e'(current_state))
      PHASE_YELLOW: begin
        load_bin  = REM_W'(YELLOW_SEC);
        load_tens = YELLOW_BCD[7:4];
        load_ones = YELLOW_BCD[3:0];
      end
      PHASE_RED: begin
        load_bin  = REM_W'(RED_SEC);
        load_tens = RED_BCD[7:4];
        load_ones = RED_BCD[3:0];
      end
      default: ;
    endcase
  end

  // Load beats tick; at zero the counters hold until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining      <= '0;
      remaining_tens <= '0;
      remaining_ones <= '0;
      armed          <= 1'b0;
    end else if (timer_load) begin
      remaining      <= load_bin;
      remaining_tens <= load_tens;
      remaining_ones <= load_ones;
      armed          <= 1'b1;
    end else if (tick && (remaining != '0)) begin
      remaining <= remaining - REM_W'(1);
      if (remaining_ones == 4'd0) begin
        remaining_ones <= 4'd9;
        remaining_tens <= remaining_tens - 4'd1;
      end else begin
        remaining_ones <= remaining_ones - 4'd1;
      end
    end
  end

  assign timer_zero = armed && (remaining == '0);

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer with a small light-FSM model for the closed-loop run.
module tb_traffic_phase_timer;

  localparam int TICK_DIV   = 4;
  localparam int GREEN_SEC  = 5;
  localparam int YELLOW_SEC = 2;
  localparam int RED_SEC    = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] drv_state = 2'b00;
  logic       drv_load = 1'b0;
  logic       loop_en = 1'b0;
  logic [1:0] fsm_state;
  logic       fsm_load;
  logic [1:0] dut_state;
  logic       dut_load;
  logic       timer_zero;
  logic [6:0] remaining;
  logic [3:0] remaining_tens;
  logic [3:0] remaining_ones;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign dut_state = loop_en ? fsm_state : drv_state;
  assign dut_load  = loop_en ? fsm_load  : drv_load;

  traffic_phase_timer #(
    .TICK_DIV   (TICK_DIV),
    .GREEN_SEC  (GREEN_SEC),
    .YELLOW_SEC (YELLOW_SEC),
    .RED_SEC    (RED_SEC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .current_state  (dut_state),
    .timer_load     (dut_load),
    .timer_zero     (timer_zero),
    .remaining      (remaining),
    .remaining_tens (remaining_tens),
    .remaining_ones (remaining_ones)
  );

  // Light FSM model: one-cycle load after each state change, ignores timer_zero while loading.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_state <= 2'b00;
      fsm_load  <= 1'b1;
    end else if (fsm_load) begin
      fsm_load <= 1'b0;
    end else if (timer_zero) begin
      fsm_state <= successor(fsm_state);
      fsm_load  <= 1'b1;
    end
  end

  function automatic logic [1:0] successor(input logic [1:0] st);
    case (st)
      2'b00:   return 2'b01;
      2'b01:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int phase_cycles(input logic [1:0] st);
    case (st)
      2'b01:   return YELLOW_SEC * TICK_DIV + 2;
      2'b10:   return RED_SEC * TICK_DIV + 2;
      default: return GREEN_SEC * TICK_DIV + 2;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] st, input logic ld);
    drv_state = st;
    drv_load  = ld;
  endtask

  task automatic checkCount(input string tag, input int exp_val, input logic exp_zero);
    checkOutput({tag, "_bin"}, int'(remaining), exp_val);
    checkOutput({tag, "_tens"}, int'(remaining_tens), exp_val / 10);
    checkOutput({tag, "_ones"}, int'(remaining_ones), exp_val % 10);
    checkOutput({tag, "_zero"}, int'(timer_zero), int'(exp_zero));
  endtask

  // Loads a phase and leaves the bench at the negedge right after the load edge.
  task automatic loadPhase(input logic [1:0] st);
    @(negedge clk);
    applyStimulus(st, 1'b1);
    @(negedge clk);
    applyStimulus(st, 1'b0);
  endtask

  initial begin
    int exp_val;
    int run;
    int measured;
    logic [1:0] prev;
    logic seen_change;

    $display("[TB] start");
    repeat (2) @(negedge clk);
    checkCount("reset", 0, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkCount("post_reset_idle", 0, 1'b0);

    // Basic green countdown: 5..0, four cycles per second, zero 20 cycles after load.
    loadPhase(2'b00);
    checkCount("green_c0", 5, 1'b0);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      exp_val = (c / TICK_DIV >= GREEN_SEC) ? 0 : GREEN_SEC - c / TICK_DIV;
      checkCount("green", exp_val, c >= GREEN_SEC * TICK_DIV);
    end

    // Red exercises the BCD borrow 10 -> 09.
    loadPhase(2'b10);
    checkCount("red_c0", 12, 1'b0);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      exp_val = (c / TICK_DIV >= RED_SEC) ? 0 : RED_SEC - c / TICK_DIV;
      checkCount("red", exp_val, c >= RED_SEC * TICK_DIV);
    end

    // Load coinciding with a tick at remaining=3 selects yellow without decrementing.
    loadPhase(2'b00);
    repeat (11) @(negedge clk);
    checkCount("pre_tick_load", 3, 1'b0);
    applyStimulus(2'b01, 1'b1);
    @(negedge clk);
    applyStimulus(2'b01, 1'b0);
    checkCount("tick_load", 2, 1'b0);
    repeat (3) @(negedge clk);
    checkCount("tick_load_hold", 2, 1'b0);
    @(negedge clk);
    checkCount("tick_load_dec", 1, 1'b0);
    repeat (4) @(negedge clk);
    checkCount("tick_load_expire", 0, 1'b1);

    // Mid-count reload held three cycles off the tick phase; counting restarts on release.
    loadPhase(2'b10);
    repeat (6) @(negedge clk);
    checkCount("hold_pre", 11, 1'b0);
    applyStimulus(2'b01, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkCount("hold_load", 2, 1'b0);
    end
    applyStimulus(2'b01, 1'b0);
    repeat (3) @(negedge clk);
    checkCount("hold_wait", 2, 1'b0);
    @(negedge clk);
    checkCount("hold_dec", 1, 1'b0);

    // Illegal code loads green, then the count sits at zero with no underflow.
    loadPhase(2'b11);
    checkCount("illegal_load", 5, 1'b0);
    repeat (20) @(negedge clk);
    checkCount("illegal_expire", 0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkCount("zero_hold", 0, 1'b1);
    end

    // Asynchronous reset between edges aborts a running count.
    loadPhase(2'b00);
    repeat (9) @(negedge clk);
    checkCount("pre_abort", 3, 1'b0);
    #1 rst = 1'b1;
    #1 checkCount("abort", 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checkOutput("after_abort_zero", int'(timer_zero), 0);
    end
    loadPhase(2'b01);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checkOutput("rearm_zero", int'(timer_zero), int'(c >= YELLOW_SEC * TICK_DIV));
    end

    // Closed loop with the FSM model: six full phases in order with the right lengths.
    @(negedge clk);
    rst = 1'b1;
    loop_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prev = fsm_state;
    run = 0;
    measured = 0;
    seen_change = 1'b0;
    for (int c = 0; c < 600 && measured < 6; c++) begin
      @(negedge clk);
      run++;
      if (fsm_state != prev) begin
        if (seen_change) begin
          checkOutput("phase_len", run, phase_cycles(prev));
          measured++;
        end
        checkOutput("phase_next", int'(fsm_state), int'(successor(prev)));
        seen_change = 1'b1;
        prev = fsm_state;
        run = 0;
      end
    end
    checkOutput("phase_count", measured, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
